// File: rtl/fm_demod_pkg.sv
// Shared types and constants for the FM demodulator sequencing controller.
package fm_demod_pkg;

    // Controller states; the encoding is visible to software through st_state.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_PRIME = 2'd2,
        ST_RUN   = 2'd3
    } fm_state_e;

    // Demod pipeline is 5 deep; one extra cycle covers the registered IQ stage.
    localparam int FLUSH_CYCLES_MIN = 6;

    localparam logic [7:0] DEFAULT_INTERVAL = 8'd1;

    // An interval of zero is meaningless to the demodulator, so map it to 1.
    function automatic logic [7:0] map_interval(input logic [7:0] iv);
        return (iv == 8'd0) ? DEFAULT_INTERVAL : iv;
    endfunction

endpackage

// File: rtl/fm_demod_ctrl_if.sv
// Streaming signals between IQ source, demodulator and audio sink.
// The controller connects through the master modport, the environment through slave.
interface fm_demod_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 32
);
    logic                     s_iq_valid;
    logic signed [DATA_W-1:0] s_i_data;
    logic signed [DATA_W-1:0] s_q_data;
    logic                     m_iq_valid;
    logic signed [DATA_W-1:0] m_i_data;
    logic signed [DATA_W-1:0] m_q_data;
    logic signed [OUT_W-1:0]  fm_data;
    logic                     fm_valid;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_valid;

    modport master (
        input  s_iq_valid, s_i_data, s_q_data, fm_data, fm_valid,
        output m_iq_valid, m_i_data, m_q_data, out_data, out_valid
    );

    modport slave (
        output s_iq_valid, s_i_data, s_q_data, fm_data, fm_valid,
        input  m_iq_valid, m_i_data, m_q_data, out_data, out_valid
    );
endinterface

// File: rtl/fm_squelch_det.sv
// Squelch detector: |I|+|Q| magnitude, threshold compare and hold counter.
// Squelch is asserted while SQ_HOLD consecutive low samples have been seen.
module fm_squelch_det #(
    parameter int DATA_W  = 16,
    parameter int SQ_HOLD = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic                     valid_i,
    input  logic signed [DATA_W-1:0] i_i,
    input  logic signed [DATA_W-1:0] q_i,
    input  logic        [DATA_W:0]   thresh_i,
    output logic                     squelch_o
);
    localparam int CNT_W = (SQ_HOLD < 1) ? 1 : $clog2(SQ_HOLD + 1);
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_POS  = {1'b0, {(DATA_W-1){1'b1}}};

    // Saturating absolute value so the most-negative code cannot wrap.
    function automatic logic [DATA_W-1:0] sat_abs(input logic [DATA_W-1:0] x);
        if (x == MOST_NEG) begin
            return MAX_POS;
        end else if (x[DATA_W-1]) begin
            return -x;
        end else begin
            return x;
        end
    endfunction

    logic [DATA_W:0]  mag;
    logic [CNT_W-1:0] low_cnt_q, low_cnt_d;

    // Magnitude and low-run counter update.
    always_comb begin
        mag       = {1'b0, sat_abs(i_i)} + {1'b0, sat_abs(q_i)};
        low_cnt_d = low_cnt_q;
        if (clr_i) begin
            low_cnt_d = '0;
        end else if (valid_i) begin
            if (mag < thresh_i) begin
                if (low_cnt_q != CNT_W'(SQ_HOLD)) begin
                    low_cnt_d = low_cnt_q + CNT_W'(1);
                end
            end else begin
                low_cnt_d = '0;
            end
        end
    end

    // Low-run counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            low_cnt_q <= '0;
        end else begin
            low_cnt_q <= low_cnt_d;
        end
    end

    assign squelch_o = (low_cnt_q == CNT_W'(SQ_HOLD));

endmodule

// File: rtl/fm_demod_ctrl.sv
// FM demodulator sequencing controller: gates the IQ feed, owns the demod
// sample interval (applied only after a pipeline flush), drops warm-up outputs.
// Optional squelch: define FM_DEMOD_CTRL_SQUELCH_EN.
module fm_demod_ctrl
    import fm_demod_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int OUT_W        = 32,
    parameter int FLUSH_CYCLES = 8,
    parameter int WARMUP_OUTS  = 4,
    parameter int SQ_HOLD      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_enable,
    input  logic [7:0]          cfg_interval,
    input  logic                cfg_update,
    fm_demod_ctrl_if.master     bus,
    output logic [7:0]          demod_interval,
    output logic [1:0]          st_state,
    output logic [15:0]         st_discard_cnt,
    output logic                st_busy
`ifdef FM_DEMOD_CTRL_SQUELCH_EN
   ,input  logic [DATA_W:0]     sq_thresh,
    output logic                st_squelch
`endif
);
    localparam int FLUSH_W = $clog2(FLUSH_CYCLES);
    localparam int WARM_W  = (WARMUP_OUTS == 0) ? 1 : $clog2(WARMUP_OUTS + 1);

    if (FLUSH_CYCLES < FLUSH_CYCLES_MIN) begin : g_bad_flush
        $error("FLUSH_CYCLES too small to drain the demod pipeline");
    end
    if (SQ_HOLD < 1) begin : g_bad_hold
        $error("SQ_HOLD must be at least 1");
    end

    fm_state_e            state_q, state_d;
    logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [WARM_W-1:0]    warm_cnt_q, warm_cnt_d;
    logic                 pend_flag_q, pend_flag_d;
    logic [7:0]           pend_int_q, pend_int_d;
    logic [7:0]           interval_q, interval_d;
    logic [15:0]          discard_q, discard_d;
    logic                 iq_vld_q;
    logic [DATA_W-1:0]    i_q, q_q;
    logic [OUT_W-1:0]     out_data_q, out_data_d;
    logic                 out_valid_q;
    logic                 feed_open;
    logic [7:0]           upd_int;

    assign feed_open = (state_q == ST_PRIME) || (state_q == ST_RUN);
    assign upd_int   = map_interval(cfg_interval);

    // Next-state, pending-interval and counter logic.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        warm_cnt_d  = warm_cnt_q;
        pend_flag_d = pend_flag_q;
        pend_int_d  = pend_int_q;
        interval_d  = interval_q;
        discard_d   = discard_q;

        if (cfg_update) begin
            pend_flag_d = 1'b1;
            pend_int_d  = upd_int;
        end

        case (state_q)
            ST_IDLE: begin
                flush_cnt_d = '0;
                if (cfg_enable) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (!cfg_enable) begin
                    state_d     = ST_IDLE;
                    flush_cnt_d = '0;
                end else if (flush_cnt_q == FLUSH_W'(FLUSH_CYCLES - 1)) begin
                    // An update landing on the final count is applied directly.
                    if (cfg_update) begin
                        interval_d = upd_int;
                    end else if (pend_flag_q) begin
                        interval_d = pend_int_q;
                    end
                    pend_flag_d = 1'b0;
                    flush_cnt_d = '0;
                    warm_cnt_d  = '0;
                    state_d     = ST_PRIME;
                end else begin
                    flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
                end
            end
            ST_PRIME: begin
                if (bus.fm_valid && (WARMUP_OUTS != 0)) begin
                    warm_cnt_d = warm_cnt_q + WARM_W'(1);
                    if (discard_q != '1) discard_d = discard_q + 16'd1;
                end
                if (!cfg_enable) begin
                    state_d = ST_IDLE;
                end else if (cfg_update) begin
                    state_d = ST_FLUSH;
                end else if ((WARMUP_OUTS == 0) ||
                             (bus.fm_valid && (warm_cnt_q == WARM_W'(WARMUP_OUTS - 1)))) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!cfg_enable) begin
                    state_d = ST_IDLE;
                end else if (cfg_update) begin
                    state_d = ST_FLUSH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            warm_cnt_q  <= '0;
            pend_flag_q <= 1'b0;
            pend_int_q  <= DEFAULT_INTERVAL;
            interval_q  <= DEFAULT_INTERVAL;
            discard_q   <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            warm_cnt_q  <= warm_cnt_d;
            pend_flag_q <= pend_flag_d;
            pend_int_q  <= pend_int_d;
            interval_q  <= interval_d;
            discard_q   <= discard_d;
        end
    end

`ifdef FM_DEMOD_CTRL_SQUELCH_EN
    logic sq_active;

    fm_squelch_det #(
        .DATA_W  (DATA_W),
        .SQ_HOLD (SQ_HOLD)
    ) u_squelch (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (!feed_open),
        .valid_i   (bus.m_iq_valid),
        .i_i       (i_q),
        .q_i       (q_q),
        .thresh_i  (sq_thresh),
        .squelch_o (sq_active)
    );

    assign st_squelch = sq_active;
    assign out_data_d = sq_active ? '0 : bus.fm_data;
`else
    assign out_data_d = bus.fm_data;
`endif

    // Registered IQ feed and audio output stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            iq_vld_q    <= 1'b0;
            i_q         <= '0;
            q_q         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            iq_vld_q    <= bus.s_iq_valid;
            i_q         <= bus.s_i_data;
            q_q         <= bus.s_q_data;
            out_data_q  <= out_data_d;
            out_valid_q <= bus.fm_valid && (state_q == ST_RUN);
        end
    end

    // Strobe is gated by the current state so a flush blocks the feed immediately.
    assign bus.m_iq_valid = iq_vld_q && feed_open;
    assign bus.m_i_data   = i_q;
    assign bus.m_q_data   = q_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;

    assign demod_interval = interval_q;
    assign st_state       = state_q;
    assign st_discard_cnt = discard_q;
    assign st_busy        = (state_q == ST_FLUSH) || (state_q == ST_PRIME);

endmodule

// File: tb/tb_fm_demod_ctrl.sv
// Directed self-checking bench for fm_demod_ctrl (default build and squelch build).
module tb_fm_demod_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_enable;
    logic [7:0]  cfg_interval;
    logic        cfg_update;
    logic [7:0]  demod_interval;
    logic [1:0]  st_state;
    logic [15:0] st_discard_cnt;
    logic        st_busy;
`ifdef FM_DEMOD_CTRL_SQUELCH_EN
    logic [16:0] sq_thresh;
    logic        st_squelch;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    fm_demod_ctrl_if #(.DATA_W(16), .OUT_W(32)) bus ();

    fm_demod_ctrl #(
        .DATA_W       (16),
        .OUT_W        (32),
        .FLUSH_CYCLES (8),
        .WARMUP_OUTS  (4),
        .SQ_HOLD      (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_enable     (cfg_enable),
        .cfg_interval   (cfg_interval),
        .cfg_update     (cfg_update),
        .bus            (bus),
        .demod_interval (demod_interval),
        .st_state       (st_state),
        .st_discard_cnt (st_discard_cnt),
        .st_busy        (st_busy)
`ifdef FM_DEMOD_CTRL_SQUELCH_EN
       ,.sq_thresh      (sq_thresh),
        .st_squelch     (st_squelch)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic fm_pulse(input logic [31:0] d);
        bus.fm_data  = d;
        bus.fm_valid = 1'b1;
        tick();
        bus.fm_valid = 1'b0;
    endtask

    task automatic warmup();
        for (int i = 0; i < 4; i++) begin
            fm_pulse(32'hA000_0000 + 32'(i));
            check("warm_drop", 32'(bus.out_valid), 32'd0);
        end
    endtask

    task automatic update(input logic [7:0] iv);
        cfg_interval = iv;
        cfg_update   = 1'b1;
        tick();
        cfg_update   = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        cfg_enable     = 1'b0;
        cfg_interval   = 8'd0;
        cfg_update     = 1'b0;
        bus.s_iq_valid = 1'b1;
        bus.s_i_data   = 16'sd1000;
        bus.s_q_data   = -16'sd1000;
        bus.fm_valid   = 1'b0;
        bus.fm_data    = '0;
`ifdef FM_DEMOD_CTRL_SQUELCH_EN
        sq_thresh      = 17'd100;
`endif
        ticks(2);

        // Reset state
        check("rst_state",    32'(st_state), 32'd0);
        check("rst_interval", 32'(demod_interval), 32'd1);
        check("rst_discard",  32'(st_discard_cnt), 32'd0);
        check("rst_outvld",   32'(bus.out_valid), 32'd0);
        check("rst_iqvld",    32'(bus.m_iq_valid), 32'd0);
        check("rst_idata",    32'(bus.m_i_data), 32'd0);
        check("rst_busy",     32'(st_busy), 32'd0);

        rst = 1'b0;
        tick();
        check("idle_state", 32'(st_state), 32'd0);
        check("idle_iqvld", 32'(bus.m_iq_valid), 32'd0);
        check("idata_reg",  32'(bus.m_i_data), 32'd1000);
        check("qdata_reg",  32'(bus.m_q_data), 32'hFFFF_FC18);

        // Enable: 8 flush cycles with the feed blocked, then PRIME
        cfg_enable = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            check("flush_state", 32'(st_state), 32'd1);
            check("flush_iqvld", 32'(bus.m_iq_valid), 32'd0);
            tick();
        end
        check("prime_state", 32'(st_state), 32'd2);
        check("prime_iqvld", 32'(bus.m_iq_valid), 32'd1);
        check("prime_busy",  32'(st_busy), 32'd1);
        warmup();
        check("run_state",    32'(st_state), 32'd3);
        check("discard_4",    32'(st_discard_cnt), 32'd4);
        check("run_busy",     32'(st_busy), 32'd0);
        fm_pulse(32'h1234_5678);
        check("first_outvld", 32'(bus.out_valid), 32'd1);
        check("first_data",   bus.out_data, 32'h1234_5678);
        tick();
        check("strobe_1cyc",  32'(bus.out_valid), 32'd0);

        // Update to 5 while running
        update(8'd5);
        check("upd_state",    32'(st_state), 32'd1);
        check("upd_iqvld",    32'(bus.m_iq_valid), 32'd0);
        check("upd_int_hold", 32'(demod_interval), 32'd1);
        ticks(7);
        check("upd_flush7",   32'(st_state), 32'd1);
        check("upd_int_pre",  32'(demod_interval), 32'd1);
        tick();
        check("upd_prime",    32'(st_state), 32'd2);
        check("upd_int_5",    32'(demod_interval), 32'd5);
        warmup();
        check("discard_8",    32'(st_discard_cnt), 32'd8);
        check("run2_state",   32'(st_state), 32'd3);

        // Interval 0 maps to 1
        update(8'd0);
        ticks(8);
        check("zero_prime",   32'(st_state), 32'd2);
        check("zero_int",     32'(demod_interval), 32'd1);
        warmup();
        check("discard_12",   32'(st_discard_cnt), 32'd12);

        // Two updates inside one flush: latest wins, counter not restarted
        update(8'd3);
        ticks(2);
        update(8'd7);
        ticks(4);
        check("dbl_flush",    32'(st_state), 32'd1);
        check("dbl_int_pre",  32'(demod_interval), 32'd1);
        tick();
        check("dbl_prime",    32'(st_state), 32'd2);
        check("dbl_int_7",    32'(demod_interval), 32'd7);
        warmup();
        check("discard_16",   32'(st_discard_cnt), 32'd16);
        check("run3_state",   32'(st_state), 32'd3);

        // Disable in the same cycle as fm_valid in RUN
        cfg_enable   = 1'b0;
        bus.fm_data  = 32'h0000_CAFE;
        bus.fm_valid = 1'b1;
        tick();
        bus.fm_valid = 1'b0;
        check("dis_outvld",   32'(bus.out_valid), 32'd1);
        check("dis_data",     bus.out_data, 32'h0000_CAFE);
        check("dis_state",    32'(st_state), 32'd0);
        fm_pulse(32'h0000_BEEF);
        check("dis_no_out",   32'(bus.out_valid), 32'd0);
        check("dis_iqvld",    32'(bus.m_iq_valid), 32'd0);

        // Update in IDLE held until enable
        update(8'd9);
        check("idle_upd_st",  32'(st_state), 32'd0);
        check("idle_upd_int", 32'(demod_interval), 32'd7);
        cfg_enable = 1'b1;
        tick();
        ticks(8);
        check("idle_upd_pr",  32'(st_state), 32'd2);
        check("idle_upd_9",   32'(demod_interval), 32'd9);

        // Update in PRIME together with fm_valid: sample still discarded
        bus.fm_data  = 32'h1;
        bus.fm_valid = 1'b1;
        cfg_interval = 8'd2;
        cfg_update   = 1'b1;
        tick();
        bus.fm_valid = 1'b0;
        cfg_update   = 1'b0;
        check("pr_upd_state", 32'(st_state), 32'd1);
        check("pr_upd_disc",  32'(st_discard_cnt), 32'd17);
        check("pr_upd_out",   32'(bus.out_valid), 32'd0);
        // Disable in FLUSH keeps the pending interval
        cfg_enable = 1'b0;
        tick();
        check("fl_dis_state", 32'(st_state), 32'd0);
        cfg_enable = 1'b1;
        tick();
        ticks(8);
        check("fl_dis_prime", 32'(st_state), 32'd2);
        check("fl_dis_int2",  32'(demod_interval), 32'd2);

        // Reset mid-operation
        fm_pulse(32'h2);
        fm_pulse(32'h3);
        check("discard_19",   32'(st_discard_cnt), 32'd19);
        rst = 1'b1;
        bus.s_iq_valid = 1'b0;
        tick();
        check("mid_rst_st",   32'(st_state), 32'd0);
        check("mid_rst_int",  32'(demod_interval), 32'd1);
        check("mid_rst_disc", 32'(st_discard_cnt), 32'd0);
        check("mid_rst_iqv",  32'(bus.m_iq_valid), 32'd0);

`ifdef FM_DEMOD_CTRL_SQUELCH_EN
        // Squelch: 16 low samples engage, one high sample releases
        rst = 1'b0;
        tick();
        ticks(8);
        warmup();
        check("sq_run",       32'(st_state), 32'd3);
        bus.s_i_data   = 16'sd10;
        bus.s_q_data   = 16'sd10;
        bus.s_iq_valid = 1'b1;
        ticks(16);
        bus.s_iq_valid = 1'b0;
        check("sq_15_low",    32'(st_squelch), 32'd0);
        tick();
        check("sq_engaged",   32'(st_squelch), 32'd1);
        fm_pulse(32'h77);
        check("sq_outvld",    32'(bus.out_valid), 32'd1);
        check("sq_zero",      bus.out_data, 32'd0);
        bus.s_i_data   = 16'sd200;
        bus.s_iq_valid = 1'b1;
        tick();
        bus.s_iq_valid = 1'b0;
        tick();
        check("sq_released",  32'(st_squelch), 32'd0);
        fm_pulse(32'h77);
        check("sq_pass_data", bus.out_data, 32'h77);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/fm_demod_ctrl.md
Name: fm_demod_ctrl

Overview:
- Sequencing controller wrapped around the FM demodulator: sits between the interpolated IQ source and the demodulator, and between the demodulator output and downstream audio filtering.
- Owns the demodulator's sample-interval setting; applies changes only at a safe point (IQ feed blocked, pipeline drained).
- Discards the warm-up outputs produced while the 5-point differentiator history is stale.
- Reports state and a discard counter for software.

Parameters:
- DATA_W, 16, IQ sample width (signed).
- OUT_W, 32, demodulated sample width (signed).
- FLUSH_CYCLES, 8, cycles the IQ feed is held off so the demod pipeline (5-cycle latency) drains; must be at least 6.
- WARMUP_OUTS, 4, number of demod outputs discarded after each (re)start.
- SQ_HOLD, 16, consecutive low-level samples before squelch engages (optional feature only).

Ports:
- clk, in, 1, sole clock.
- rst, in, 1, synchronous active-high reset.
- cfg_enable, in, 1, level; 1 = demodulation running.
- cfg_interval, in, 8, requested sample interval (0 is treated as 1).
- cfg_update, in, 1, one-cycle pulse requesting that cfg_interval be applied.
- s_iq_valid, in, 1, IQ sample strobe from the interpolator.
- s_i_data / s_q_data, in, DATA_W each, signed IQ.
- m_iq_valid, out, 1, gated strobe to the demodulator.
- m_i_data / m_q_data, out, DATA_W each, registered copies of the IQ inputs.
- demod_interval, out, 8, interval driven to the demodulator; changes only in FLUSH.
- fm_data, in, OUT_W, demodulator output.
- fm_valid, in, 1, demodulator output strobe.
- out_data, out, OUT_W, accepted demod sample.
- out_valid, out, 1, one-cycle strobe.
- st_state, out, 2, state encoding: IDLE=0, FLUSH=1, PRIME=2, RUN=3.
- st_discard_cnt, out, 16, saturating count of demod outputs discarded.
- st_busy, out, 1, high in FLUSH or PRIME.

Behaviour:
- Reset values: state IDLE; all outputs 0 except demod_interval=1.
- The pending-update flag and pending interval also reset to 0 and 1.
- IQ path is registered, 1-cycle latency: m_iq_valid = s_iq_valid delayed by one cycle AND (state is PRIME or RUN); data is registered every cycle.
- Output path is registered, 1-cycle latency: out_data <= fm_data, out_valid <= fm_valid AND state==RUN.
- IDLE: feed blocked, outputs suppressed.
  - cfg_enable=1 -> FLUSH.
- FLUSH: feed blocked; counter runs 0..FLUSH_CYCLES-1.
  - On the final count: demod_interval <= pending interval (if the pending flag is set, else unchanged); clear the flag; warm-up counter <= 0; -> PRIME.
  - If cfg_enable drops -> IDLE immediately, counter cleared.
- PRIME: feed open.
  - Each fm_valid increments the warm-up counter and st_discard_cnt (saturating at 0xFFFF); the sample is not forwarded.
  - When the WARMUP_OUTS-th output is discarded -> RUN. The first forwarded sample is output WARMUP_OUTS+1.
  - WARMUP_OUTS=0 -> go straight to RUN on the next cycle.
- RUN: pass-through.
- cfg_update in any state: latch cfg_interval (0 mapped to 1) as the pending interval and set the pending flag.
  - In PRIME or RUN this also forces -> FLUSH next cycle; an fm_valid arriving in that same cycle is still handled by the current state.
  - In FLUSH: the latest value wins; the counter is not restarted.
  - In IDLE: the value is held until the next enable.
- cfg_enable=0 in PRIME or RUN -> IDLE next cycle; the pending update is kept.
- Simultaneous cfg_enable fall and cfg_update: disable wins the transition; the update is still latched.
- rst asserted mid-operation: everything returns to reset values next edge, and st_discard_cnt clears.

Optional Feature:
- Macro: FM_DEMOD_CTRL_SQUELCH_EN, plus ports sq_thresh (in, DATA_W+1) and st_squelch (out, 1).
- When defined:
  - For each gated IQ sample, compute |I|+|Q| at DATA_W+1 bits; the most-negative input is saturated to max.
  - A low counter counts consecutive samples where |I|+|Q| < sq_thresh. Squelch asserts once the counter reaches SQ_HOLD and clears on the first sample at or above threshold.
  - While squelched, RUN outputs keep out_valid but out_data=0.
  - The low counter clears on leaving RUN or PRIME.
- When undefined: no extra ports, no squelch logic; out_data always equals fm_data.

Decomposition:
- Package fm_demod_pkg holds:
  - the state enum (2 bits, values above);
  - the FLUSH_CYCLES minimum constant (6);
  - the default interval constant (1).
- One natural sub-module, fm_squelch_det: magnitude, compare and hold counter. It is instantiated only under the macro.

Test Plan:
- Reset, then enable: with FLUSH_CYCLES=8, m_iq_valid stays 0 for 8 cycles after cfg_enable, then in PRIME the first 4 fm_valid pulses are dropped (st_discard_cnt=4) and the 5th appears on out_valid one cycle later.
- In RUN, pulse cfg_update with cfg_interval=5: next cycle state=FLUSH and m_iq_valid=0; demod_interval becomes 5 on the 8th FLUSH cycle; 4 further discards follow (count=8).
- Apply cfg_interval=0 then update: demod_interval=1.
- Two cfg_update pulses (3 then 7) inside one FLUSH: demod_interval=7, exactly one FLUSH period elapses.
- cfg_enable dropped in the same cycle as fm_valid in RUN: that sample is output, state=IDLE next cycle, no later out_valid.
- Squelch build, sq_thresh=100, feed I=Q=10 for 16 samples: st_squelch=1 and out_data=0 with out_valid kept; one sample with I=200 clears it.
